if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with a one-word hold buffer for
// ID freezes and a drain state that absorbs the ack of a request abandoned
// by a branch redirect.
// Optional feature: define IF_FETCH_COUNTER_EN to add the fetch_count output
// (number of words delivered to IF/ID with if_valid=1).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
`ifdef IF_FETCH_COUNTER_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;
    // Set during reset and for the first cycle after release so that an ack
    // belonging to a request abandoned by reset is not taken as fresh data.
    logic        r_ack_block;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_drain_addr_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_instr_nxt;
    logic        w_if_valid_nxt;
    logic        w_ack;
    logic [31:0] w_pc_inc;
    logic [31:0] w_br_pc;

    assign w_ack    = imem_ack & ~r_ack_block;
    assign w_pc_inc = r_pc + 32'd4;
    assign w_br_pc  = branch_addr & 32'hFFFF_FFFC;

    // The stale request in S_DRAIN keeps its original address until acked.
    assign imem_req  = rst & (r_state != S_HOLD);
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;

    // Next-state, PC, hold buffer and IF/ID register computation.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_if_pc_nxt      = r_if_pc;
        w_if_instr_nxt   = r_if_instr;
        w_if_valid_nxt   = r_if_valid;

        if (branch_taken) begin
            // Redirect: flush IF/ID, drop any buffered word, ignore freeze.
            w_pc_nxt       = w_br_pc;
            w_if_pc_nxt    = '0;
            w_if_instr_nxt = '0;
            w_if_valid_nxt = 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end
                S_HOLD:  w_state_nxt = S_FETCH;
                S_DRAIN: w_state_nxt = w_ack ? S_FETCH : S_DRAIN;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            // Unfrozen IF/ID defaults to a bubble unless a word lands below.
            if (!freeze) begin
                w_if_pc_nxt    = '0;
                w_if_instr_nxt = '0;
                w_if_valid_nxt = 1'b0;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_pc_nxt = w_pc_inc;
                        if (freeze) begin
                            w_hold_instr_nxt = imem_rdata;
                            w_hold_pc_nxt    = w_pc_inc;
                            w_state_nxt      = S_HOLD;
                        end else begin
                            w_if_instr_nxt = imem_rdata;
                            w_if_pc_nxt    = w_pc_inc;
                            w_if_valid_nxt = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        w_if_instr_nxt = r_hold_instr;
                        w_if_pc_nxt    = r_hold_pc;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    // State, PC, hold buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC & 32'hFFFF_FFFC;
            r_drain_addr <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_if_pc      <= '0;
            r_if_instr   <= '0;
            r_if_valid   <= 1'b0;
            r_ack_block  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_ack_block  <= 1'b0;
        end
    end

`ifdef IF_FETCH_COUNTER_EN
    logic [31:0] r_fetch_count;
    logic        w_deliver;

    // Without freeze or branch, a valid next IF/ID word is always a fresh load.
    assign w_deliver   = ~freeze & ~branch_taken & w_if_valid_nxt;
    assign fetch_count = r_fetch_count;

    // Count words delivered to IF/ID.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_count <= '0;
        end else if (w_deliver) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] XORK = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef IF_FETCH_COUNTER_EN
    logic [31:0] fetch_count;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid)
`ifdef IF_FETCH_COUNTER_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC, IF/ID contents, buffered words, stale request.
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_ifi;
    logic [31:0] m_ifp;
    bit          m_ifv;
    logic [63:0] m_hold[$];
    bit          m_stale;
    logic [31:0] m_stale_addr;
    bit          m_first;
    logic [31:0] m_cnt;

    function automatic bit exp_req();
        return (rst === 1'b1) && (m_hold.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_ifv = 1'b0;
        m_ifi = '0;
        m_ifp = '0;
    endtask

    task automatic deliver(input logic [31:0] instr, input logic [31:0] pc);
        m_ifv = 1'b1;
        m_ifi = instr;
        m_ifp = pc;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic model_update(input bit r, input bit f, input bit b,
                                input logic [31:0] ba, input bit a,
                                input logic [31:0] rd);
        bit eff;
        logic [63:0] w;
        if (!r) begin
            m_pc    = RPC & 32'hFFFF_FFFC;
            bubble();
            m_hold.delete();
            m_stale = 1'b0;
            m_first = 1'b1;
            m_cnt   = '0;
            m_known = 1'b1;
            return;
        end
        eff     = a && !m_first;
        m_first = 1'b0;
        if (b) begin
            if (m_stale)                m_stale = !eff;
            else if (m_hold.size() != 0) m_stale = 1'b0;
            else if (!eff) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_hold.delete();
            m_pc = ba & 32'hFFFF_FFFC;
            bubble();
        end else if (m_stale) begin
            if (eff) m_stale = 1'b0;
            if (!f) bubble();
        end else if (m_hold.size() != 0) begin
            if (!f) begin
                w = m_hold.pop_front();
                deliver(w[63:32], w[31:0]);
            end
        end else if (eff) begin
            if (f) m_hold.push_back({rd, m_pc + 32'd4});
            else   deliver(rd, m_pc + 32'd4);
            m_pc = m_pc + 32'd4;
        end else if (!f) begin
            bubble();
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit r, input bit f, input bit b,
                        input logic [31:0] ba, input bit a);
        bit          ack_v;
        logic [31:0] rd;
        @(negedge clk);
        if (m_known) begin
            chk1("imem_req", imem_req, exp_req());
            if (exp_req()) chk32("imem_addr", imem_addr, exp_addr());
            chk1("if_valid", if_valid, m_ifv);
            chk32("if_instr", if_instr, m_ifi);
            chk32("if_pc", if_pc, m_ifp);
`ifdef IF_FETCH_COUNTER_EN
            chk32("fetch_count", fetch_count, m_cnt);
`endif
        end
        ack_v = a && (!r || m_hold.size() == 0);
        rd    = ack_v ? (exp_addr() ^ XORK) : $urandom;
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ack     = ack_v;
        imem_rdata   = rd;
        @(posedge clk);
        model_update(r, f, b, ba, ack_v, rd);
    endtask

    initial begin
        bit          rr, rf, rb, ra;
        logic [31:0] rba;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = '0; imem_ack = 1'b0; imem_rdata = '0;

        // Reset, with an ack arriving while held in reset.
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        // Ack every cycle: sequential stream.
        repeat (6) step(1, 0, 0, 32'h0, 1);
        // Freeze for three cycles while an ack lands, then release.
        step(1, 1, 0, 32'h0, 1);
        step(1, 1, 0, 32'h0, 1);
        step(1, 1, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        // Slow memory with a branch in the first wait cycle.
        step(1, 0, 1, 32'h100, 0);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        // Second branch while draining.
        step(1, 0, 1, 32'h180, 0);
        step(1, 0, 1, 32'h1C3, 0);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        // Branch together with ack under freeze.
        step(1, 1, 1, 32'h200, 1);
        step(1, 0, 0, 32'h0, 1);
        // Wrap at the top of the address space; low branch bits ignored.
        step(1, 0, 1, 32'hFFFF_FFFF, 1);
        step(1, 0, 0, 32'h0, 1);
        #1;
        chk32("wrap_if_pc", if_pc, 32'h0000_0000);
        chk32("wrap_imem_addr", imem_addr, 32'h0000_0000);
        chk1("wrap_if_valid", if_valid, 1'b1);
        chk32("wrap_if_instr", if_instr, 32'hFFFF_FFFC ^ XORK);
        // Reset in the middle of an outstanding request.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(0, 99) != 0);
            rf  = ($urandom_range(0, 9) < 4);
            rb  = ($urandom_range(0, 9) == 0);
            ra  = ($urandom_range(0, 1) == 1);
            rba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                              : $urandom;
            step(rr, rf, rb, rba, ra);
        end
        step(1, 0, 0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
